// File: rtl/psg_fir_mc.sv
// psg_fir_mc: multi-channel, time-multiplexed serial-MAC FIR filter.
// One shared multiplier walks the taps of the selected channel, one product
// per cycle, against a single signed-magnitude coefficient bank. The result is
// rounded half toward +inf, then saturated. Bypass returns the sample as-is.
module psg_fir_mc #(
   parameter int unsigned TAPS     = 16,
   parameter int unsigned DW       = 15,
   parameter int unsigned CW       = 12,
   parameter int unsigned CHANNELS = 2,
   localparam int unsigned AW      = $clog2(TAPS),
   localparam int unsigned CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [CHW-1:0] in_ch,
   input  logic [DW-1:0]  in_data,
   output logic           out_valid,
   output logic [CHW-1:0] out_ch,
   output logic [DW-1:0]  out_data,
   input  logic           bypass,
   input  logic           coef_wr,
   input  logic [AW-1:0]  coef_adr,
   input  logic [CW:0]    coef_din,
   output logic           coef_drop,
   input  logic           coef_clr
);

   localparam int unsigned ACCW = DW + CW + AW + 1;
   localparam int unsigned PW   = DW + CW + 1;

   localparam logic [CHW:0]           NCH   = (CHW + 1)'(CHANNELS);
   localparam logic [AW-1:0]          KLAST = AW'(TAPS - 1);
   localparam logic signed [ACCW-1:0] HALF  = ACCW'(1) << (CW - 1);
   localparam logic signed [ACCW-1:0] SMAX  = ACCW'((1 << (DW - 1)) - 1);
   localparam logic signed [ACCW-1:0] SMIN  = ~SMAX;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_OUT
   } state_e;

   state_e state_q, state_d;

   logic [AW-1:0]          k_q, k_d;
   logic [CHW-1:0]         ch_q, ch_d;
   logic                   byp_q, byp_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic                   out_valid_q, out_valid_d;
   logic [CHW-1:0]         out_ch_q, out_ch_d;
   logic [DW-1:0]          out_data_q, out_data_d;
   logic                   drop_q, drop_d;

   logic [DW-1:0] tap_q  [CHANNELS][TAPS];
   logic [CW-1:0] cmag_q [TAPS];
   logic          csgn_q [TAPS];

   logic                   accept;
   logic                   ch_ok;
   logic                   coef_we;
   logic [DW-1:0]          tap_sel;
   logic signed [PW-1:0]   mul_a, mul_b, prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] rsum, rnd;
   logic [DW-1:0]          sat;

   assign accept  = in_valid && (state_q == S_IDLE);
   assign ch_ok   = {1'b0, in_ch} < NCH;
   assign coef_we = coef_wr && (state_q == S_IDLE);

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;
   assign coef_drop = drop_q;

   // Shared multiplier, rounding and saturation of the finished accumulator.
   always_comb begin
      tap_sel  = tap_q[ch_q][k_q];
      mul_a    = $signed({{(DW + 1){1'b0}}, cmag_q[k_q]});
      mul_b    = $signed({{(CW + 1){tap_sel[DW-1]}}, tap_sel});
      prod     = mul_a * mul_b;
      prod_ext = {{AW{prod[PW-1]}}, prod};
      rsum     = acc_q + HALF;
      rnd      = rsum >>> CW;
      if (rnd > SMAX) begin
         sat = SMAX[DW-1:0];
      end else if (rnd < SMIN) begin
         sat = SMIN[DW-1:0];
      end else begin
         sat = rnd[DW-1:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and handshake output; discarded channels stay in IDLE.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (accept && ch_ok) begin
               state_d = bypass ? S_OUT : S_MAC;
            end
         end
         S_MAC: begin
            if (k_q == KLAST) begin
               state_d = S_OUT;
            end
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next state: accumulate, present result, track dropped writes.
   // The bypass result is tap 0 of the latched channel, which holds the
   // accepted sample until the next accept, so no extra sample register.
   always_comb begin
      k_d         = k_q;
      ch_d        = ch_q;
      byp_d       = byp_q;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      out_ch_d    = out_ch_q;
      out_data_d  = out_data_q;
      drop_d      = drop_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d = '0;
               k_d   = '0;
               if (ch_ok) begin
                  ch_d  = in_ch;
                  byp_d = bypass;
               end
            end
         end
         S_MAC: begin
            acc_d = csgn_q[k_q] ? (acc_q - prod_ext) : (acc_q + prod_ext);
            k_d   = k_q + 1'b1;
         end
         S_OUT: begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_q;
            out_data_d  = byp_q ? tap_q[ch_q][0] : sat;
         end
         default: ;
      endcase
      if (coef_clr) begin
         drop_d = 1'b0;
      end
      if (coef_wr && (state_q != S_IDLE)) begin
         drop_d = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q         <= '0;
         ch_q        <= '0;
         byp_q       <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         drop_q      <= 1'b0;
      end else begin
         k_q         <= k_d;
         ch_q        <= ch_d;
         byp_q       <= byp_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_data_q  <= out_data_d;
         drop_q      <= drop_d;
      end
   end

   // Per-channel delay lines: shift on every accept of a valid channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
               tap_q[c][k] <= '0;
            end
         end
      end else if (accept && ch_ok) begin
         tap_q[in_ch][0] <= in_data;
         for (int unsigned k = 1; k < TAPS; k++) begin
            tap_q[in_ch][k] <= tap_q[in_ch][k-1];
         end
      end
   end

   // Coefficient bank: writable only while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            cmag_q[k] <= '0;
            csgn_q[k] <= 1'b0;
         end
      end else if (coef_we) begin
         cmag_q[coef_adr] <= coef_din[CW-1:0];
         csgn_q[coef_adr] <= coef_din[CW];
      end
   end

endmodule
